// File: rtl/marquee_pkg.sv
// Shared constants, state encodings and character helpers for the marquee
// message writer and its UART receiver.
package marquee_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ESC   = 8'h1B;
  localparam logic [7:0] PRINT_LO    = 8'h20;
  localparam logic [7:0] PRINT_HI    = 8'h60;
  localparam logic [7:0] LOWER_LO    = 8'h61;
  localparam logic [7:0] LOWER_HI    = 8'h7A;
  localparam logic [7:0] CASE_OFFSET = 8'h20;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

  typedef enum logic [1:0] {BYTE_DROP, BYTE_TERM, BYTE_ESC, BYTE_STORE} byte_class_e;

  function automatic logic is_lower(input logic [7:0] c);
    return (c >= LOWER_LO) && (c <= LOWER_HI);
  endfunction

  function automatic byte_class_e classify(input logic [7:0] c);
    byte_class_e cls;
    if ((c == ASCII_CR) || (c == ASCII_LF)) begin
      cls = BYTE_TERM;
    end else if (c == ASCII_ESC) begin
      cls = BYTE_ESC;
    end else if (((c >= PRINT_LO) && (c <= PRINT_HI)) || is_lower(c)) begin
      cls = BYTE_STORE;
    end else begin
      cls = BYTE_DROP;
    end
    return cls;
  endfunction

  function automatic logic [7:0] to_upper(input logic [7:0] c);
    return is_lower(c) ? (c - CASE_OFFSET) : c;
  endfunction

endpackage

// File: rtl/marquee_msg_writer_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, bit timer and deframing FSM.
// rx_valid / rx_ferr are decoded on the stop-bit sample cycle itself.
module uart_rx_8n1
  import marquee_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1259
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr,
  output logic       busy
);

  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

  logic            sync1_r, sync2_r;
  logic            rxd_s;
  rx_state_e       state_r;
  logic [TW-1:0]   timer_r;
  logic [2:0]      bit_idx_r;
  logic [7:0]      shift_r;
  logic            stop_sample_s;

  // Synchronizer flops preset to the idle line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rxd;
      sync2_r <= sync1_r;
    end
  end

  assign rxd_s = sync2_r;

  // Deframer: start validation at half bit, then centre sampling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      timer_r   <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          timer_r   <= '0;
          bit_idx_r <= 3'd0;
          state_r   <= rxd_s ? IDLE : START;
        end
        START: begin
          if (timer_r == HALF_M1) begin
            timer_r <= '0;
            state_r <= rxd_s ? IDLE : DATA;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        DATA: begin
          if (timer_r == FULL_M1) begin
            timer_r   <= '0;
            shift_r   <= {rxd_s, shift_r[7:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
            state_r   <= (bit_idx_r == 3'd7) ? STOP : DATA;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        STOP: begin
          if (timer_r == FULL_M1) begin
            timer_r <= '0;
            state_r <= IDLE;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        default: begin
          timer_r <= '0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign stop_sample_s = (state_r == STOP) && (timer_r == FULL_M1);
  assign rx_valid      = stop_sample_s & rxd_s;
  assign rx_ferr       = stop_sample_s & ~rxd_s;
  assign rx_byte       = shift_r;
  assign busy          = (state_r != IDLE);

endmodule

// File: rtl/marquee_msg_writer.sv
// Marquee message writer: filters received UART characters into the message
// RAM and publishes the message length on CR/LF.
module marquee_msg_writer
  import marquee_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1259,
  parameter int ADDR_W       = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [ADDR_W:0]   msg_len,
  output logic              msg_valid,
  output logic              busy,
  output logic              frame_err
);

  localparam logic [ADDR_W:0] PTR_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] PTR_FULL = {1'b1, {ADDR_W{1'b0}}};

  logic [7:0]      rx_byte_s;
  logic            rx_valid_s;
  logic            rx_ferr_s;
  logic [ADDR_W:0] ptr_r;
  byte_class_e     cls_s;
  logic [7:0]      char_s;

  uart_rx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk     (clk),
    .rst     (rst),
    .rxd     (rxd),
    .rx_byte (rx_byte_s),
    .rx_valid(rx_valid_s),
    .rx_ferr (rx_ferr_s),
    .busy    (busy)
  );

  // Classify and case-fold the byte presented on the stop-sample cycle.
  always_comb begin
    cls_s  = classify(rx_byte_s);
    char_s = to_upper(rx_byte_s);
  end

  // Pointer, RAM write and message publish; the pointer saturates at PTR_FULL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r     <= PTR_ZERO;
      wr_en     <= 1'b0;
      wr_addr   <= {ADDR_W{1'b0}};
      wr_data   <= 8'h00;
      msg_len   <= PTR_ZERO;
      msg_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      msg_valid <= 1'b0;
      frame_err <= rx_ferr_s;
      if (rx_valid_s) begin
        case (cls_s)
          BYTE_TERM: begin
            if (ptr_r != PTR_ZERO) begin
              msg_len   <= ptr_r;
              msg_valid <= 1'b1;
              ptr_r     <= PTR_ZERO;
            end
          end
          BYTE_ESC: ptr_r <= PTR_ZERO;
          BYTE_STORE: begin
            if (ptr_r != PTR_FULL) begin
              wr_en   <= 1'b1;
              wr_addr <= ptr_r[ADDR_W-1:0];
              wr_data <= char_s;
              ptr_r   <= ptr_r + {{ADDR_W{1'b0}}, 1'b1};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_marquee_msg_writer.sv
// Directed bench for marquee_msg_writer with a write/message scoreboard.
module tb_marquee_msg_writer;

  localparam int CPB    = 16;
  localparam int ADDR_W = 6;

  logic              clk;
  logic              rst;
  logic              rxd;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [ADDR_W:0]   msg_len;
  logic              msg_valid;
  logic              busy;
  logic              frame_err;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_msg[$];
  int  checks;
  int  errors;
  int  ferr_seen;
  int  busy_cnt;

  marquee_msg_writer #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .msg_len  (msg_len),
    .msg_valid(msg_valid),
    .busy     (busy),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input int addr, input logic [7:0] data);
    wr_t e;
    e.addr = ADDR_W'(addr);
    e.data = data;
    exp_wr.push_back(e);
  endtask

  // One cycle: drive changes land at negedge, outputs are observed here too.
  task automatic step();
    wr_t e;
    int  m;
    @(negedge clk);
    if (wr_en) begin
      chk("wr_expected", 32'(exp_wr.size() > 0), 32'd1);
      if (exp_wr.size() > 0) begin
        e = exp_wr.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", 32'(wr_data), 32'(e.data));
      end
    end
    if (msg_valid) begin
      chk("msg_expected", 32'(exp_msg.size() > 0), 32'd1);
      if (exp_msg.size() > 0) begin
        m = exp_msg.pop_front();
        chk("msg_len", 32'(msg_len), 32'(m));
      end
    end
    if (frame_err) ferr_seen++;
    if (busy) busy_cnt++;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (CPB) step();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) step();
    end
    rxd = stop_bit;
    repeat (CPB) step();
    rxd = 1'b1;
    repeat (24) step();
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b1);
  endtask

  task automatic check_drained(input string tag);
    chk({tag, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
    chk({tag, "_msg_left"}, 32'(exp_msg.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({tag, "_msg_len"}, 32'(msg_len), 32'd0);
    chk({tag, "_msg_valid"}, 32'(msg_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    ferr_seen = 0;
    busy_cnt  = 0;
    rst       = 1'b1;
    rxd       = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    repeat (5) step();
    check_idle_outputs("post_reset");

    // 1: "AB" CR
    push_wr(0, 8'h41); push_wr(1, 8'h42); exp_msg.push_back(2);
    send(8'h41); send(8'h42); send(8'h0D);
    chk("t1_no_ferr", 32'(ferr_seen), 32'd0);
    chk("t1_msg_len_hold", 32'(msg_len), 32'd2);
    check_drained("t1");

    // 2: "hi" CR LF folds case, LF ignored
    push_wr(0, 8'h48); push_wr(1, 8'h49); exp_msg.push_back(2);
    send(8'h68); send(8'h69); send(8'h0D); send(8'h0A);
    check_drained("t2");

    // 2b: range edges: 0x60 kept, 0x7A folded, 0x7B and 0x01 dropped, 0x20 kept
    push_wr(0, 8'h60); push_wr(1, 8'h5A); push_wr(2, 8'h20); exp_msg.push_back(3);
    send(8'h60); send(8'h7A); send(8'h7B); send(8'h01); send(8'h20); send(8'h0A);
    check_drained("t2b");

    // 3: framing error then a clean byte at addr 0
    ferr_seen = 0;
    send_frame(8'h41, 1'b0);
    chk("t3_ferr_count", 32'(ferr_seen), 32'd1);
    push_wr(0, 8'h42); exp_msg.push_back(1);
    send(8'h42); send(8'h0D);
    chk("t3_ferr_after", 32'(ferr_seen), 32'd1);
    check_drained("t3");

    // 4: 4-cycle glitch is rejected at the start-bit check
    busy_cnt = 0;
    rxd = 1'b0;
    repeat (4) step();
    rxd = 1'b1;
    repeat (30) step();
    chk("t4_busy_seen", 32'(busy_cnt > 0), 32'd1);
    chk("t4_busy_max", 32'(busy_cnt <= 8), 32'd1);
    chk("t4_busy_idle", 32'(busy), 32'd0);
    chk("t4_no_ferr", 32'(ferr_seen), 32'd1);
    push_wr(0, 8'h4B); exp_msg.push_back(1);
    send(8'h4B); send(8'h0D);
    check_drained("t4");

    // 5: overflow saturates at 64, then ESC restarts the message
    for (int i = 0; i < 64; i++) push_wr(i, 8'h58);
    exp_msg.push_back(64);
    for (int i = 0; i < 70; i++) send(8'h58);
    send(8'h0D);
    chk("t5_msg_len_full", 32'(msg_len), 32'd64);
    check_drained("t5a");
    push_wr(0, 8'h41); push_wr(1, 8'h42);
    send(8'h41); send(8'h42); send(8'h1B);
    chk("t5_esc_len_hold", 32'(msg_len), 32'd64);
    push_wr(0, 8'h43); exp_msg.push_back(1);
    send(8'h43); send(8'h0D);
    chk("t5_msg_len_esc", 32'(msg_len), 32'd1);
    check_drained("t5b");

    // 6: reset during data bit 3 drops the partial message
    push_wr(0, 8'h51);
    send(8'h51);
    rxd = 1'b0;
    repeat (CPB) step();
    rxd = 1'b0;
    repeat (3 * CPB + CPB / 2) step();
    chk("t6_busy_mid", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_idle_outputs("t6_rst");
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) step();
    push_wr(0, 8'h5A); exp_msg.push_back(1);
    send(8'h5A); send(8'h0D);
    chk("t6_msg_len", 32'(msg_len), 32'd1);
    check_drained("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
